systolic_writeback: RTL and testbench
=====================================

Name: systolic_writeback

Overview:
- Downstream stage of the systolic MAC array; consumes one anti-diagonal result vector per beat (ARRAY_SIZE lanes of 2*DATA_WIDTH+5 signed accumulators).
- Per lane: round-shift requantization, optional ReLU and saturation to signed DATA_WIDTH.
- Packs lanes into SRAM words in the same byte order the array's loaders use, and writes them to the output SRAM at consecutive addresses.
- Counts beats and pulses done after the last write.

Parameters:
ARRAY_SIZE, 8, number of lanes per beat.
DATA_WIDTH, 8, output element width; must be 8.
SRAM_DATA_WIDTH, 32, SRAM word width; 4 elements per word.
ACC_WIDTH, 2*DATA_WIDTH+5 (21), input lane width.
ADDR_WIDTH, 10, output SRAM address width.
NWORDS, (ARRAY_SIZE+3)/4, SRAM banks per beat.

Ports:
clk  in  1  clock.
srstn  in  1  synchronous active-low reset.
start  in  1  one-cycle pulse; latches configuration and begins a job.
row_total  in  9  number of beats in the job.
base_addr  in  ADDR_WIDTH  first write address.
shift_amt  in  5  right-shift amount, 0..20.
relu_en  in  1  clamp negative results to 0.
in_valid  in  1  acc_vec valid.
in_ready  out  1  block accepts a beat this cycle.
acc_vec  in  ARRAY_SIZE*ACC_WIDTH  signed lanes; lane i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].
sram_wen  out  1  write strobe, active high.
sram_waddr  out  ADDR_WIDTH  write address, shared by all banks.
sram_wdata_packed  out  NWORDS*SRAM_DATA_WIDTH  bank k at bits [k*32 +: 32].
busy  out  1  high while the FSM is in RUN or DRAIN.
done  out  1  one-cycle pulse at the end of a job.

Behaviour:
- Reset (srstn=0 at a clk edge): FSM goes to IDLE. in_ready, sram_wen, busy and done are 0. sram_waddr and sram_wdata_packed are 0. Beat counter, address counter and pipeline valids are cleared. Reset applies mid-job, and any in-flight write is dropped.

FSM:
- IDLE: on start, latch row_total, base_addr, shift_amt and relu_en, and clear the counters. If row_total==0, go to DONE with no writes; otherwise go to RUN.
- RUN: in_ready=1. A beat is accepted when in_valid && in_ready. After the beat that makes accept_cnt==row_total, go to DRAIN.
- DRAIN: in_ready=0. Wait until the pipeline is empty, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE. in_valid is ignored outside RUN.

Datapath (2 stages, no stalls; SRAM always accepts):
- Stage 1, registered on accept: per lane r = (acc + (shift_amt>0 ? 1<<(shift_amt-1) : 0)) >>> shift_amt. The adder is ACC_WIDTH+1 bits signed so the rounding add cannot overflow; the shift is arithmetic.
- Stage 2, registered: if relu_en and r<0, then r=0. Saturate r to [-128,127]. Lane i goes into bank i/4, bits [31-8*(i%4) -: 8]. Unused byte slots in the last bank are 0.
- sram_wen=1 in the cycle after stage 2 is loaded, so the write appears 2 cycles after acceptance. sram_waddr = base_addr + write index.
- Throughput is 1 beat/cycle. Back-to-back accepts produce back-to-back writes at consecutive addresses.
- The address wraps modulo 2^ADDR_WIDTH with no error.
- sram_wdata_packed holds its last value when sram_wen=0.
- busy is 1 in RUN and DRAIN. done asserts one cycle after the final sram_wen.

Test Plan:
- ARRAY_SIZE=8, row_total=3, base=0x010, shift=0, relu=0; 3 consecutive beats with lane i = i-4 -> writes at 0x010..0x012, each with bank0=0xFCFDFEFF and bank1=0x00010203. done pulses one cycle after the third write.
- shift=4, lanes = 24, 23, -24, -25 -> stage-1 results 2, 1, -1, -2 (round half up, +8 then >>>4). Bytes 0x02, 0x01, 0xFF, 0xFE.
- shift=0, lanes = 300, -300, 127, -128; relu=0 -> 0x7F, 0x80, 0x7F, 0x80. Same beat with relu=1 -> 0x7F, 0x00, 0x7F, 0x00.
- in_valid toggling 1,0,1,1 with row_total=3 -> exactly 3 writes, address gap-free, each 2 cycles after its accept. in_ready=0 once the third beat is accepted.
- row_total=0 start -> no sram_wen, done one cycle later, busy never high. start asserted while busy -> no effect on counters or configuration.
- srstn=0 for one cycle during the 2nd of 4 beats -> all outputs 0, FSM in IDLE, no further writes. A new start then runs a full job correctly.

Source files
------------

// File: rtl/systolic_writeback.sv
// Writeback stage for the systolic MAC array: requantizes each accumulator lane
// (round-shift, optional ReLU, saturate), packs lanes into SRAM words and writes one word set per beat.
module systolic_writeback #(
  parameter int ARRAY_SIZE      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ACC_WIDTH       = 2*DATA_WIDTH+5,
  parameter int ADDR_WIDTH      = 10,
  parameter int NWORDS          = (ARRAY_SIZE+3)/4
) (
  input  logic                              clk,
  input  logic                              srstn,
  input  logic                              start,
  input  logic [8:0]                        row_total,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [4:0]                        shift_amt,
  input  logic                              relu_en,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]   acc_vec,
  output logic                              sram_wen,
  output logic [ADDR_WIDTH-1:0]             sram_waddr,
  output logic [NWORDS*SRAM_DATA_WIDTH-1:0] sram_wdata_packed,
  output logic                              busy,
  output logic                              done
);

  localparam int EPW = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1)-1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(DATA_WIDTH-1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [8:0]              row_total_reg;
  logic [ADDR_WIDTH-1:0]   base_addr_reg;
  logic [4:0]              shift_reg;
  logic                    relu_reg;
  logic [8:0]              accept_cnt_reg;
  logic [ADDR_WIDTH-1:0]   wr_cnt_reg;
  logic                    s1_valid_reg;
  logic                    accept;
  logic                    last_accept;
  logic signed [ACC_WIDTH:0] round_add;
  logic [NWORDS*SRAM_DATA_WIDTH-1:0] wdata_next;

  assign accept      = in_valid && (state_reg == S_RUN);
  assign last_accept = accept && ((accept_cnt_reg + 9'd1) == row_total_reg);

  always_ff @(posedge clk) begin
    if (!srstn) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = (row_total == 9'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_accept) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // The last beat is in stage 2 (writing) once stage 1 empties, so done follows that write.
        if (!s1_valid_reg) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      row_total_reg  <= '0;
      base_addr_reg  <= '0;
      shift_reg      <= '0;
      relu_reg       <= 1'b0;
      accept_cnt_reg <= '0;
      wr_cnt_reg     <= '0;
    end else if (state_reg == S_IDLE && start) begin
      row_total_reg  <= row_total;
      base_addr_reg  <= base_addr;
      shift_reg      <= shift_amt;
      relu_reg       <= relu_en;
      accept_cnt_reg <= '0;
      wr_cnt_reg     <= '0;
    end else begin
      if (accept)       accept_cnt_reg <= accept_cnt_reg + 9'd1;
      if (s1_valid_reg) wr_cnt_reg     <= wr_cnt_reg + ADDR_WIDTH'(1);
    end
  end

  // Half-LSB rounding constant; zero when no shift is requested.
  always_comb begin
    round_add = '0;
    if (shift_reg != 5'd0) round_add = (ACC_WIDTH+1)'(1) << (shift_reg - 5'd1);
  end

  always_ff @(posedge clk) begin
    if (!srstn) s1_valid_reg <= 1'b0;
    else        s1_valid_reg <= accept;
  end

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      logic signed [ACC_WIDTH:0] lane_ext;
      logic signed [ACC_WIDTH:0] lane_sum;
      logic signed [ACC_WIDTH:0] lane_shift;
      logic signed [ACC_WIDTH:0] s1_lane_reg;
      logic signed [ACC_WIDTH:0] lane_clip;
      logic [DATA_WIDTH-1:0]     lane_byte;

      // One extra bit of headroom keeps the rounding add from overflowing.
      assign lane_ext   = {acc_vec[gi*ACC_WIDTH+ACC_WIDTH-1], acc_vec[gi*ACC_WIDTH +: ACC_WIDTH]};
      assign lane_sum   = lane_ext + round_add;
      assign lane_shift = lane_sum >>> shift_reg;

      always_ff @(posedge clk) begin
        if (accept) s1_lane_reg <= lane_shift;
      end

      always_comb begin
        lane_clip = s1_lane_reg;
        if (relu_reg && (s1_lane_reg < 0)) lane_clip = '0;
        lane_byte = lane_clip[DATA_WIDTH-1:0];
        if (lane_clip > SAT_MAX)      lane_byte = SAT_MAX[DATA_WIDTH-1:0];
        else if (lane_clip < SAT_MIN) lane_byte = SAT_MIN[DATA_WIDTH-1:0];
      end

      // Lane 0 lands in the most significant byte of bank 0, matching the loaders.
      assign wdata_next[(gi/EPW)*SRAM_DATA_WIDTH + (EPW-1-(gi%EPW))*DATA_WIDTH +: DATA_WIDTH] = lane_byte;
    end

    for (gi = ARRAY_SIZE; gi < NWORDS*EPW; gi++) begin : g_pad
      assign wdata_next[(gi/EPW)*SRAM_DATA_WIDTH + (EPW-1-(gi%EPW))*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!srstn) begin
      sram_wen          <= 1'b0;
      sram_waddr        <= '0;
      sram_wdata_packed <= '0;
    end else begin
      sram_wen <= s1_valid_reg;
      if (s1_valid_reg) begin
        sram_waddr        <= base_addr_reg + wr_cnt_reg;
        sram_wdata_packed <= wdata_next;
      end
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
// Randomized scoreboard bench for systolic_writeback: the driver pushes expected writes from an
// arithmetic reference model, and a negedge monitor pops and compares each SRAM write and done pulse.
module tb_systolic_writeback;

  localparam int AS  = 8;
  localparam int AW  = 21;
  localparam int ADW = 10;
  localparam int NW  = 2;

  logic              clk = 1'b0;
  logic              srstn = 1'b0;
  logic              start = 1'b0;
  logic [8:0]        row_total = '0;
  logic [ADW-1:0]    base_addr = '0;
  logic [4:0]        shift_amt = '0;
  logic              relu_en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [AS*AW-1:0]  acc_vec = '0;
  logic              sram_wen;
  logic [ADW-1:0]    sram_waddr;
  logic [NW*32-1:0]  sram_wdata_packed;
  logic              busy;
  logic              done;

  systolic_writeback #(
    .ARRAY_SIZE(AS), .DATA_WIDTH(8), .SRAM_DATA_WIDTH(32),
    .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .NWORDS(NW)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start), .row_total(row_total),
    .base_addr(base_addr), .shift_amt(shift_amt), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .acc_vec(acc_vec),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr),
    .sram_wdata_packed(sram_wdata_packed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [ADW-1:0]   addr;
    logic [NW*32-1:0] data;
    int               cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  exp_done_cyc = -1;
  bit  done_seen = 1'b0;

  int             m_rows = 0;
  int             m_accepted = 0;
  logic [ADW-1:0] m_base = '0;
  int             m_shift = 0;
  bit             m_relu = 1'b0;

  int cur_lanes[AS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: floor((acc + half) / 2^shift), then ReLU, clamp, and byte placement by lane index.
  function automatic logic [NW*32-1:0] model_word(input int lanes[AS], input int sh, input bit relu);
    logic [NW*32-1:0] w;
    longint num, d, q;
    logic [7:0] b;
    w = '0;
    for (int i = 0; i < AS; i++) begin
      num = longint'(lanes[i]);
      if (sh > 0) num = num + (longint'(1) << (sh - 1));
      d = longint'(1) << sh;
      q = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
      if (relu && q < 0) q = 0;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      b = q[7:0];
      w[(i/4)*32 + 8*(3 - (i%4)) +: 8] = b;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (sram_wen) begin
      $display("write cycle=%0d addr=%03h data=%016h", cyc, sram_waddr, sram_wdata_packed);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr=%0h required no write (cycle %0d)", sram_waddr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", 64'(sram_waddr), 64'(mon_e.addr));
        check("wdata", 64'(sram_wdata_packed), 64'(mon_e.data));
        check("write_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (done) begin
      check("done_cycle", 64'(cyc), 64'(exp_done_cyc));
      exp_done_cyc = -1;
      done_seen = 1'b1;
    end
  end

  task automatic do_start(input int rows, input logic [ADW-1:0] base, input int sh, input bit relu);
    @(negedge clk);
    start = 1'b1; row_total = rows[8:0]; base_addr = base; shift_amt = sh[4:0]; relu_en = relu;
    in_valid = 1'b0;
    check("busy_before_start", 64'(busy), 64'(0));
    m_rows = rows; m_accepted = 0; m_base = base; m_shift = sh; m_relu = relu;
    done_seen = 1'b0;
    if (rows == 0) exp_done_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(rows > 0));
  endtask

  task automatic drive_beat(input int lanes[AS], input bit valid, input bit poke);
    bit exp_ready;
    int v;
    @(negedge clk);
    in_valid = valid;
    for (int i = 0; i < AS; i++) begin
      v = lanes[i];
      acc_vec[i*AW +: AW] = v[AW-1:0];
    end
    if (poke) begin
      start = 1'b1; row_total = 9'd1; base_addr = 10'h3ff; shift_amt = 5'd9; relu_en = 1'b1;
    end else begin
      start = 1'b0;
    end
    exp_ready = (m_accepted < m_rows);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    if (valid && exp_ready) begin
      exp_q.push_back('{addr: m_base + m_accepted[ADW-1:0],
                        data: model_word(lanes, m_shift, m_relu),
                        cyc: cyc + 2});
      m_accepted++;
      if (m_accepted == m_rows) exp_done_cyc = cyc + 3;
    end
  endtask

  task automatic drive_idle();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    #1;
    for (int i = 0; i < 40; i++) begin
      if (done_seen) break;
      @(negedge clk);
      #1;
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual no done pulse required done within 40 cycles");
    end
    check("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic rand_lanes();
    logic [31:0] r;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < AS; i++) begin
      r = $urandom;
      if (mode == 0) cur_lanes[i] = int'({{11{r[AW-1]}}, r[AW-1:0]});
      else if (mode == 1) cur_lanes[i] = int'($urandom_range(0, 600)) - 300;
      else cur_lanes[i] = int'($urandom_range(0, 4000)) - 2000;
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_wen", 64'(sram_wen), 64'(0));
    check("rst_waddr", 64'(sram_waddr), 64'(0));
    check("rst_wdata", 64'(sram_wdata_packed), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    srstn = 1'b1;

    // Three back-to-back beats, lane i = i-4
    do_start(3, 10'h010, 0, 0);
    for (int i = 0; i < AS; i++) cur_lanes[i] = i - 4;
    repeat (3) drive_beat(cur_lanes, 1'b1, 1'b0);
    drive_idle();
    wait_done();

    // Round-half-up shift
    do_start(1, 10'h020, 4, 0);
    cur_lanes = '{24, 23, -24, -25, 0, 0, 0, 0};
    drive_beat(cur_lanes, 1'b1, 1'b0);
    drive_idle();
    wait_done();

    // Saturation without and with ReLU
    cur_lanes = '{300, -300, 127, -128, 0, 0, 0, 0};
    do_start(1, 10'h030, 0, 0);
    drive_beat(cur_lanes, 1'b1, 1'b0);
    drive_idle();
    wait_done();
    do_start(1, 10'h031, 0, 1);
    drive_beat(cur_lanes, 1'b1, 1'b0);
    drive_idle();
    wait_done();

    // in_valid 1,0,1,1 then one extra offered beat after the job is full
    do_start(3, 10'h040, 2, 0);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    rand_lanes(); drive_beat(cur_lanes, 1'b0, 1'b0);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    drive_idle();
    wait_done();

    // Empty job
    do_start(0, 10'h050, 0, 0);
    wait_done();
    drive_idle();
    check("busy_empty_job", 64'(busy), 64'(0));

    // start while busy must not disturb the running job
    do_start(4, 10'h060, 3, 1);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b1);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    drive_idle();
    wait_done();

    // Reset during the second of four beats
    do_start(4, 10'h070, 1, 0);
    rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    srstn = 1'b0;
    exp_q.delete();
    m_rows = 0; m_accepted = 0; exp_done_cyc = -1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    check("mid_rst_wen", 64'(sram_wen), 64'(0));
    check("mid_rst_waddr", 64'(sram_waddr), 64'(0));
    check("mid_rst_wdata", 64'(sram_wdata_packed), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    srstn = 1'b1;
    repeat (4) begin
      rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    end
    drive_idle();
    do_start(4, 10'h080, 5, 1);
    repeat (4) begin
      rand_lanes(); drive_beat(cur_lanes, 1'b1, 1'b0);
    end
    drive_idle();
    wait_done();

    // Randomized jobs, some starting near the top of the address space
    for (int j = 0; j < 30; j++) begin
      int rows, sh;
      logic [ADW-1:0] base;
      rows = $urandom_range(1, 6);
      base = (j % 5 == 0) ? 10'h3fd : ADW'($urandom);
      sh = $urandom_range(0, 20);
      do_start(rows, base, sh, 1'($urandom_range(0, 1)));
      while (m_accepted < m_rows) begin
        rand_lanes();
        drive_beat(cur_lanes, ($urandom_range(0, 3) != 0), 1'b0);
      end
      drive_idle();
      wait_done();
    end

    repeat (5) drive_idle();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
